// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, branch
// condition codes and the opcode legality limit.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [2:0] COND_NONE = 3'd0;
    localparam logic [2:0] COND_EQ   = 3'd1;
    localparam logic [2:0] COND_NE   = 3'd2;
    localparam logic [2:0] COND_LT   = 3'd3;
    localparam logic [2:0] COND_GE   = 3'd4;

    localparam logic [3:0] OP_MAX = 4'd7;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_sequencer_cond.sv
// Combinational branch-condition evaluator: turns a condition code plus the
// ALU zero/negative flags into a taken bit, and flags unknown codes.
module alu_cond_eval
    import alu_sequencer_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       zero,
    input  logic       neg,
    output logic       taken,
    output logic       cond_illegal
);

    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
        taken        = 1'b0;
        cond_illegal = 1'b0;
        case (cond)
            COND_NONE: taken = 1'b0;
            COND_EQ:   taken = zero;
            COND_NE:   taken = ~zero;
            COND_LT:   taken = neg;
            COND_GE:   taken = ~neg;
            default:   cond_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Single-outstanding ALU sequencer: accepts a request, issues it to an external
// registered ALU, captures result and branch outcome, and holds the response.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_cond,
    output logic             alu_en,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_operand0,
    output logic [31:0]      alu_operand1,
    input  logic [31:0]      alu_res,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_res,
    output logic             rsp_taken,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    state_t     state;
    state_t     next_state;
    logic [2:0] cond_q;
    logic [2:0] eval_cond;
    logic       taken;
    logic       cond_illegal;
    logic       req_legal;

    // Legality is judged on the live request in IDLE, the branch on the latched one later.
    assign eval_cond = (state == IDLE) ? req_cond : cond_q;
    assign req_legal = op_legal(req_op) && !cond_illegal;

    alu_cond_eval u_cond_eval (
        .cond         (eval_cond),
        .zero         (alu_zero),
        .neg          (alu_neg),
        .taken        (taken),
        .cond_illegal (cond_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        alu_en     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = req_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                alu_en     = 1'b1;
                next_state = CAPTURE;
            end
            CAPTURE: next_state = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op       <= 4'd0;
            alu_operand0 <= 32'd0;
            alu_operand1 <= 32'd0;
            cond_q       <= COND_NONE;
            rsp_res      <= 32'd0;
            rsp_taken    <= 1'b0;
            rsp_err      <= 1'b0;
            op_count     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_op       <= req_op;
                        alu_operand0 <= req_a;
                        alu_operand1 <= req_b;
                        cond_q       <= req_cond;
                        if (!req_legal) begin
                            rsp_res   <= 32'd0;
                            rsp_taken <= 1'b0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ISSUE: op_count <= op_count + CNT_W'(1);
                CAPTURE: begin
                    // The ALU result is only valid for this one cycle after issue.
                    rsp_res   <= alu_res;
                    rsp_taken <= taken;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a registered ALU stand-in, a
// latency-level reference model compared every cycle, and directed vectors.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_cond;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [31:0] alu_operand0;
    logic [31:0] alu_operand1;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_neg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_taken;
    logic        rsp_err;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cond     (req_cond),
        .alu_en       (alu_en),
        .alu_op       (alu_op),
        .alu_operand0 (alu_operand0),
        .alu_operand1 (alu_operand1),
        .alu_res      (alu_res),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_res      (rsp_res),
        .rsp_taken    (rsp_taken),
        .rsp_err      (rsp_err),
        .op_count     (op_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return b;
        endcase
    endfunction

    function automatic logic cond_taken(input logic [2:0] cond, input logic [31:0] r);
        case (cond)
            3'd1:    return r == 32'd0;
            3'd2:    return r != 32'd0;
            3'd3:    return r[31];
            3'd4:    return !r[31];
            default: return 1'b0;
        endcase
    endfunction

    // ALU stand-in: registers its result on an issue edge and clears it on the next edge.
    logic [31:0] alu_next;
    assign alu_next = alu_fn(alu_op, alu_operand0, alu_operand1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res  <= 32'd0;
            alu_zero <= 1'b0;
            alu_neg  <= 1'b0;
        end else if (alu_en) begin
            alu_res  <= alu_next;
            alu_zero <= (alu_next == 32'd0);
            alu_neg  <= alu_next[31];
        end else begin
            alu_res  <= 32'd0;
            alu_zero <= 1'b0;
            alu_neg  <= 1'b0;
        end
    end

    // Reference model: one request in flight, tracked by age in cycles since acceptance.
    logic        m_busy;
    logic        m_legal;
    int          m_age;
    logic [15:0] m_cnt;
    logic [3:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_res;
    logic        m_taken;
    logic        m_err;
    logic        req_legal_m;
    logic [31:0] req_fn;
    logic        exp_valid;
    logic        exp_alu_en;

    assign req_legal_m = (req_op <= 4'd7) && (req_cond <= 3'd4);
    assign req_fn      = alu_fn(req_op, req_a, req_b);
    assign exp_valid   = m_busy && (!m_legal || m_age >= 2);
    assign exp_alu_en  = m_busy && m_legal && (m_age == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_legal <= 1'b0;
            m_age   <= 0;
            m_cnt   <= 16'd0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  <= 1'b1;
                m_age   <= 0;
                m_legal <= req_legal_m;
                m_op    <= req_op;
                m_a     <= req_a;
                m_b     <= req_b;
                m_res   <= req_legal_m ? req_fn : 32'd0;
                m_taken <= req_legal_m ? cond_taken(req_cond, req_fn) : 1'b0;
                m_err   <= !req_legal_m;
            end
        end else begin
            if (exp_valid && rsp_ready) m_busy <= 1'b0;
            if (m_age < 2) m_age <= m_age + 1;
            if (m_age == 0 && m_legal) m_cnt <= m_cnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        check("req_ready", req_ready, !m_busy);
        check("rsp_valid", rsp_valid, exp_valid);
        check("alu_en", alu_en, exp_alu_en);
        check("op_count", op_count, m_cnt);
        if (exp_alu_en) begin
            check("alu_op", alu_op, m_op);
            check("alu_operand0", alu_operand0, m_a);
            check("alu_operand1", alu_operand1, m_b);
        end
        if (exp_valid) begin
            check("rsp_res", rsp_res, m_res);
            check("rsp_taken", rsp_taken, m_taken);
            check("rsp_err", rsp_err, m_err);
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cond, input int stall,
                        output logic [31:0] res, output logic taken, output logic err, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cond  = cond;
        rsp_ready = (stall == 0);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
        res   = rsp_res;
        taken = rsp_taken;
        err   = rsp_err;
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_ready", req_ready, 1'b0);
            check("stall_res", rsp_res, res);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        t;
        logic        e;
        int          lat;

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 4'd0;
        req_a = 32'd0;
        req_b = 32'd0;
        req_cond = 3'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_alu_en", alu_en, 1'b0);
        check("rst_alu_op", alu_op, 4'd0);
        check("rst_operands", {alu_operand0, alu_operand1}, 64'd0);
        check("rst_rsp", {rsp_valid, rsp_taken, rsp_err}, 3'b000);
        check("rst_rsp_res", rsp_res, 32'd0);
        check("rst_op_count", op_count, 16'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);

        send(4'd0, 32'd5, 32'd7, 3'd0, 0, r, t, e, lat);
        check("add_res", r, 32'd12);
        check("add_taken_err", {t, e}, 2'b00);
        check("add_latency", lat, 3);
        check("add_count", op_count, 16'd1);

        send(4'd1, 32'd3, 32'd3, 3'd1, 0, r, t, e, lat);
        check("sub_eq_res", r, 32'd0);
        check("sub_eq_taken", t, 1'b1);
        send(4'd1, 32'd3, 32'd3, 3'd2, 0, r, t, e, lat);
        check("sub_ne_taken", t, 1'b0);
        check("sub_count", op_count, 16'd3);

        send(4'd1, 32'd2, 32'd5, 3'd3, 0, r, t, e, lat);
        check("lt_res", r, 32'hFFFF_FFFD);
        check("lt_taken", t, 1'b1);

        send(4'd7, 32'd0, 32'h8000_0000, 3'd4, 0, r, t, e, lat);
        check("op7_ge_res", r, 32'h8000_0000);
        check("op7_ge_taken_err", {t, e}, 2'b00);
        check("legal_count", op_count, 16'd5);

        send(4'd9, 32'd1, 32'd2, 3'd0, 0, r, t, e, lat);
        check("ill_op_err", e, 1'b1);
        check("ill_op_res_taken", {r, t}, 33'd0);
        check("ill_op_latency", lat, 1);
        send(4'd0, 32'd1, 32'd2, 3'd6, 0, r, t, e, lat);
        check("ill_cond_err", e, 1'b1);
        send(4'd8, 32'd1, 32'd2, 3'd0, 0, r, t, e, lat);
        check("ill_op8_err", e, 1'b1);
        send(4'd0, 32'd1, 32'd2, 3'd5, 0, r, t, e, lat);
        check("ill_cond5_err", e, 1'b1);
        check("ill_count", op_count, 16'd5);

        send(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 3'd0, 5, r, t, e, lat);
        check("bp_res", r, 32'h0000_F000);
        check("bp_count", op_count, 16'd6);

        // Abort an operation while it sits in CAPTURE.
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 4'd0;
        req_a = 32'd10;
        req_b = 32'd20;
        req_cond = 3'd0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_count", op_count, 16'd0);
        check("abort_valid", rsp_valid, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 1'b0);
        end

        send(4'd0, 32'd100, 32'd23, 3'd0, 0, r, t, e, lat);
        check("post_abort_res", r, 32'd123);
        check("post_abort_count", op_count, 16'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
